// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg -- shared definitions for the multiplexed bit-scan controller.
//   NUM_CH  : number of mux channels scanned per word
//   SEL_W   : width of the mux select bus
//   CNT_W   : width of the select-settle down-counter
//   state_t : controller FSM encoding
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// mux_scan_settle_cnt -- select-settle down-counter.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset, clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : reload value
//   dec      : decrement by one, holds at zero
//   zero     : count is zero
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl -- scans a 16:1 mux one channel at a time and assembles the
// sampled bits into a 16-bit word handed off with a valid/ready handshake.
// Each channel spends SETTLE_CYCLES cycles letting the mux output settle after
// sel is applied, then one cycle sampling it.
// Parameters:
//   SETTLE_CYCLES : settle wait per channel, 1..15
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : request one scan (honoured only when idle)
//   abort      : cancel a scan in progress
//   sel        : mux channel select
//   mux_out    : mux output bit being sampled
//   word       : last completed scan, bit i = channel i
//   word_valid : word holds a completed scan awaiting acceptance
//   word_ready : consumer accepts word
//   busy       : scan in progress
// Build option:
//   MUX_SCAN_CONTINUOUS_EN : after each accepted word, start the next scan
//                            immediately without waiting for start.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic [15:0]      word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [NUM_CH-1:0]  shreg;
  logic [NUM_CH-1:0]  shreg_nx;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  // Shift register with the current sample merged in; lets the last channel's
  // bit land in word on the same edge it is captured.
  always_comb begin
    shreg_nx      = shreg;
    shreg_nx[sel] = mux_out;
  end

  // Counter reloads whenever a channel's settle phase begins.
  always_comb begin
    cnt_load = 1'b0;
    if ((state == IDLE) && start) begin
      cnt_load = 1'b1;
    end
    if ((state == SAMPLE) && !abort && (sel != LAST_SEL)) begin
      cnt_load = 1'b1;
    end
`ifdef MUX_SCAN_CONTINUOUS_EN
    if ((state == HOLD) && word_valid && word_ready) begin
      cnt_load = 1'b1;
    end
`endif
  end

  assign cnt_dec = (state == SETTLE) && !abort;

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      shreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            sel   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            sel   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
          end else if (cnt_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            sel   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
          end else begin
            shreg <= shreg_nx;
            if (sel == LAST_SEL) begin
              word       <= shreg_nx;
              word_valid <= 1'b1;
              sel        <= '0;
              busy       <= 1'b0;
              state      <= HOLD;
            end else begin
              sel   <= sel + 1'b1;
              state <= SETTLE;
            end
          end
        end
        HOLD: begin
          if (word_valid && word_ready) begin
            word_valid <= 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
            state <= SETTLE;
            sel   <= '0;
            shreg <= '0;
            busy  <= 1'b1;
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl -- directed bench for mux_scan_ctrl. A behavioural 16:1 mux
// (pattern register indexed by sel) feeds mux_out. dut0 uses default settings,
// dut1 uses SETTLE_CYCLES=1. Defining MUX_SCAN_CONTINUOUS_EN selects the
// continuous-mode sequence instead of the single-shot sequences.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, word_ready;
  logic [3:0]  sel;
  logic        mux_out;
  logic [15:0] word;
  logic        word_valid, busy;
  logic [15:0] pat;

  logic        s1_start, s1_abort, s1_ready;
  logic [3:0]  s1_sel;
  logic        s1_mux;
  logic [15:0] s1_word;
  logic        s1_valid, s1_busy;
  logic [15:0] pat1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign mux_out = pat[sel];
  assign s1_mux  = pat1[s1_sel];

  mux_scan_ctrl dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .sel        (sel),
    .mux_out    (mux_out),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s1_start),
    .abort      (s1_abort),
    .sel        (s1_sel),
    .mux_out    (s1_mux),
    .word       (s1_word),
    .word_valid (s1_valid),
    .word_ready (s1_ready),
    .busy       (s1_busy)
  );

  typedef struct {
    logic [15:0] pat;
    logic        with_abort;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   {28'd0, sel}, 32'd0);
    check({tag, "_word"},  {16'd0, word}, 32'd0);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  // Start a scan of pattern p on dut0 (called at a negedge) and wait for
  // word_valid; checks latency, sel sequence and busy during the scan.
  task automatic run_scan(input logic [15:0] p, input logic ab);
    int lat;
    bit sel_ok, busy_ok;
    lat = -1; sel_ok = 1'b1; busy_ok = 1'b1;
    pat = p; start = 1'b1; abort = ab;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (word_valid) begin
        lat = k;
        break;
      end
      if (sel !== 4'(k / 3)) sel_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("scan_latency", lat, 32'd48);
    check("scan_sel_seq", {31'd0, sel_ok}, 32'd1);
    check("scan_busy", {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; word_ready = 1'b0; pat = '0;
    s1_start = 1'b0; s1_abort = 1'b0; s1_ready = 1'b0; pat1 = '0;

    vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
    vecs[1] = '{16'h0000, 1'b0, 16'h0000};
    vecs[2] = '{16'hFFFF, 1'b1, 16'hFFFF};
    vecs[3] = '{16'h8001, 1'b0, 16'h8001};
    vecs[4] = '{16'h1234, 1'b1, 16'h1234};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

`ifndef MUX_SCAN_CONTINUOUS_EN
    // word_ready while nothing is valid has no effect
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    word_ready = 1'b0;
    check("idle_ready_valid", {31'd0, word_valid}, 32'd0);
    check("idle_ready_busy", {31'd0, busy}, 32'd0);

    // table of scans, each accepted immediately
    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].pat, vecs[i].with_abort);
      check($sformatf("vec%0d_word", i), {16'd0, word}, {16'd0, vecs[i].exp_word});
      check($sformatf("vec%0d_hold_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_hold_sel", i), {28'd0, sel}, 32'd0);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      check($sformatf("vec%0d_ack_valid", i), {31'd0, word_valid}, 32'd0);
      check($sformatf("vec%0d_ack_word", i), {16'd0, word}, {16'd0, vecs[i].exp_word});
    end

    // HOLD: stable without word_ready; start/abort ignored
    begin
      bit stable;
      stable = 1'b1;
      run_scan(16'h3C5A, 1'b0);
      for (int c = 0; c < 10; c++) begin
        start = (c == 3);
        abort = (c == 5);
        @(negedge clk);
        if (word !== 16'h3C5A || word_valid !== 1'b1 || busy !== 1'b0 || sel !== 4'd0)
          stable = 1'b0;
      end
      start = 1'b0; abort = 1'b0;
      check("hold_stable", {31'd0, stable}, 32'd1);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      check("hold_ack_valid", {31'd0, word_valid}, 32'd0);
      check("hold_ack_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("hold_no_restart", {31'd0, busy}, 32'd0);
      check("hold_word_kept", {16'd0, word}, 32'h3C5A);
    end

    // abort in SAMPLE of channel 7
    begin
      bit quiet;
      pat = 16'hFFFF; start = 1'b1;
      for (int k = 0; k <= 23; k++) begin
        @(negedge clk);
        start = 1'b0;
      end
      check("abort_pre_sel", {28'd0, sel}, 32'd7);
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_sel", {28'd0, sel}, 32'd0);
      check("abort_valid", {31'd0, word_valid}, 32'd0);
      check("abort_word", {16'd0, word}, 32'h3C5A);
      quiet = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (word_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      check("abort_quiet", {31'd0, quiet}, 32'd1);
    end

    // one-cycle reset at channel 9, then an immediate full scan
    pat = 16'h0F0F; start = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_pre_sel", {28'd0, sel}, 32'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    run_scan(16'h6C39, 1'b0);
    check("midrst_word", {16'd0, word}, 32'h6C39);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;

    // SETTLE_CYCLES=1 with repeated starts while busy
    begin
      int lat1, nvalid;
      logic [15:0] w1;
      lat1 = -1; nvalid = 0; w1 = '0;
      pat1 = 16'hBEEF; s1_ready = 1'b1; s1_start = 1'b1;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        s1_start = ((k % 5) == 0) && (k < 30);
        if (s1_valid) begin
          if (lat1 < 0) begin
            lat1 = k;
            w1 = s1_word;
          end
          nvalid++;
        end
      end
      s1_ready = 1'b0;
      check("s1_latency", lat1, 32'd32);
      check("s1_valid_count", nvalid, 32'd1);
      check("s1_word", {16'd0, w1}, 32'hBEEF);
      check("s1_idle_busy", {31'd0, s1_busy}, 32'd0);
    end
`else
    // continuous mode: back-to-back words with word_ready held high
    begin
      int t1, t2;
      logic [15:0] w1, w2;
      bit quiet;
      t1 = -1; t2 = -1; w1 = '0; w2 = '0;
      pat = 16'hA5C3; word_ready = 1'b1; start = 1'b1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (word_valid) begin
          if (t1 < 0) begin
            t1 = k; w1 = word; pat = 16'h5AA5;
          end else begin
            t2 = k; w2 = word;
            break;
          end
        end
      end
      check("cont_first_latency", t1, 32'd48);
      check("cont_period", t2 - t1, 32'd49);
      check("cont_word1", {16'd0, w1}, 32'hA5C3);
      check("cont_word2", {16'd0, w2}, 32'h5AA5);
      @(negedge clk);
      check("cont_restart_busy", {31'd0, busy}, 32'd1);
      check("cont_restart_valid", {31'd0, word_valid}, 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("cont_abort_busy", {31'd0, busy}, 32'd0);
      check("cont_abort_sel", {28'd0, sel}, 32'd0);
      check("cont_abort_word", {16'd0, word}, 32'h5AA5);
      quiet = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (word_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      check("cont_abort_quiet", {31'd0, quiet}, 32'd1);
      word_ready = 1'b0;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
